// File: rtl/card_datapath_if.sv
// Bus between the dealing state machine (master) and the baccarat hand datapath (slave).
// The master drives the one-hot load strobes and reads back cards, scores and the deal count.
interface card_datapath_if;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic [3:0] new_card;
    logic [3:0] pcard1;
    logic [3:0] pcard2;
    logic [3:0] pcard3;
    logic [3:0] dcard1;
    logic [3:0] dcard2;
    logic [3:0] dcard3;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [7:0] deal_count;

    modport master (
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        input  new_card, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
        input  pscore, dscore, deal_count
    );

    modport slave (
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        output new_card, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
        output pscore, dscore, deal_count
    );
endinterface

// File: rtl/card_datapath.sv
// Baccarat hand datapath: cycling 1..13 card source, six card slots, mod-10 hand scores
// and a saturating count of cards dealt since reset.
module card_datapath (
    input  logic           slow_clock,
    input  logic           resetb,
    card_datapath_if.slave bus
);
    localparam int NUM_SLOTS = 6;

    logic [NUM_SLOTS-1:0] load_vec;
    logic [3:0]           card_q [NUM_SLOTS];
    logic [3:0]           card_d [NUM_SLOTS];
    logic [3:0]           new_card_q;
    logic [3:0]           new_card_d;
    logic [7:0]           deal_count_q;
    logic [7:0]           deal_count_d;
    logic [2:0]           load_cnt;
    logic [8:0]           count_sum;

    // Slots 0..2 are player cards 1..3, slots 3..5 are dealer cards 1..3.
    assign load_vec = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                       bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

    function automatic logic [3:0] card_value(input logic [3:0] card);
        return (card != 4'd0 && card <= 4'd9) ? card : 4'd0;
    endfunction

    function automatic logic [3:0] hand_score(input logic [3:0] c1, input logic [3:0] c2,
                                              input logic [3:0] c3);
        logic [4:0] sum;
        sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
        if (sum >= 5'd20)
            return 4'(sum - 5'd20);
        else if (sum >= 5'd10)
            return 4'(sum - 5'd10);
        else
            return sum[3:0];
    endfunction

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        assign card_d[gi] = load_vec[gi] ? new_card_q : card_q[gi];
    end

    always_comb begin
        load_cnt = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            load_cnt = load_cnt + {2'b00, load_vec[i]};
        end
    end

    // Carry out of the 9-bit sum means the count passed 255.
    assign count_sum    = {1'b0, deal_count_q} + {6'b000000, load_cnt};
    assign deal_count_d = count_sum[8] ? 8'hFF : count_sum[7:0];
    assign new_card_d   = (new_card_q == 4'd13) ? 4'd1 : new_card_q + 4'd1;

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                card_q[i] <= 4'd0;
            end
            new_card_q   <= 4'd1;
            deal_count_q <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                card_q[i] <= card_d[i];
            end
            new_card_q   <= new_card_d;
            deal_count_q <= deal_count_d;
        end
    end

    assign bus.new_card   = new_card_q;
    assign bus.pcard1     = card_q[0];
    assign bus.pcard2     = card_q[1];
    assign bus.pcard3     = card_q[2];
    assign bus.dcard1     = card_q[3];
    assign bus.dcard2     = card_q[4];
    assign bus.dcard3     = card_q[5];
    assign bus.pscore     = hand_score(card_q[0], card_q[1], card_q[2]);
    assign bus.dscore     = hand_score(card_q[3], card_q[4], card_q[5]);
    assign bus.deal_count = deal_count_q;
endmodule

// File: tb/tb_card_datapath.sv
// Self-checking bench for card_datapath: directed hand scenarios plus random loads/resets,
// all compared against a behavioural model of the dealing rules.
module tb_card_datapath;
    logic slow_clock;
    logic resetb;

    card_datapath_if bus ();

    card_datapath dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .bus        (bus)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    int num_checks = 0;
    int num_errors = 0;
    int edge_no    = 0;

    // Reference model: cards by slot (0..2 player, 3..5 dealer), edges since reset, total dealt.
    int m_card [6];
    int m_edges;
    int m_dealt;

    task automatic check_eq(input string tag, input int observed, input int expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, observed, expected, edge_no);
        end
    endtask

    function automatic int card_val(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int score(input int a, input int b, input int c);
        return (card_val(a) + card_val(b) + card_val(c)) % 10;
    endfunction

    function automatic int m_new_card();
        return (m_edges % 13) + 1;
    endfunction

    function automatic int m_count();
        return (m_dealt > 255) ? 255 : m_dealt;
    endfunction

    task automatic check_all();
        check_eq("new_card",   int'(bus.new_card),   m_new_card());
        check_eq("pcard1",     int'(bus.pcard1),     m_card[0]);
        check_eq("pcard2",     int'(bus.pcard2),     m_card[1]);
        check_eq("pcard3",     int'(bus.pcard3),     m_card[2]);
        check_eq("dcard1",     int'(bus.dcard1),     m_card[3]);
        check_eq("dcard2",     int'(bus.dcard2),     m_card[4]);
        check_eq("dcard3",     int'(bus.dcard3),     m_card[5]);
        check_eq("pscore",     int'(bus.pscore),     score(m_card[0], m_card[1], m_card[2]));
        check_eq("dscore",     int'(bus.dscore),     score(m_card[3], m_card[4], m_card[5]));
        check_eq("deal_count", int'(bus.deal_count), m_count());
    endtask

    // ld bit order: p1, p2, p3, d1, d2, d3 (bit 0 = p1).
    task automatic do_edge(input logic [5:0] ld, input logic rb);
        int pre_new;
        int pre_pscore;
        bus.load_pcard1 = ld[0];
        bus.load_pcard2 = ld[1];
        bus.load_pcard3 = ld[2];
        bus.load_dcard1 = ld[3];
        bus.load_dcard2 = ld[4];
        bus.load_dcard3 = ld[5];
        resetb          = rb;
        #1;
        check_eq("no_comb_pscore", int'(bus.pscore), score(m_card[0], m_card[1], m_card[2]));
        @(posedge slow_clock);
        edge_no++;
        pre_new = m_new_card();
        if (!rb) begin
            foreach (m_card[i]) m_card[i] = 0;
            m_edges = 0;
            m_dealt = 0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (ld[i]) begin
                    m_card[i] = pre_new;
                    m_dealt++;
                end
            end
            m_edges++;
        end
        #1;
        pre_pscore = int'(bus.pscore);
        $display("edge %0d rb=%b ld=%b new=%0d p=%0d,%0d,%0d d=%0d,%0d,%0d ps=%0d ds=%0d cnt=%0d",
                 edge_no, rb, ld, bus.new_card, bus.pcard1, bus.pcard2, bus.pcard3,
                 bus.dcard1, bus.dcard2, bus.dcard3, pre_pscore, bus.dscore, bus.deal_count);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_edge(6'b000000, 1'b1);
    endtask

    initial begin
        foreach (m_card[i]) m_card[i] = 0;
        m_edges = 0;
        m_dealt = 0;

        // Reset with every load asserted: loads must be ignored.
        do_edge(6'b111111, 1'b0);
        do_edge(6'b111111, 1'b0);
        check_eq("rst_new_card", int'(bus.new_card), 1);
        check_eq("rst_pcard3", int'(bus.pcard3), 0);
        check_eq("rst_count", int'(bus.deal_count), 0);

        // Initial two-card deal, then third cards.
        do_edge(6'b000001, 1'b1);
        do_edge(6'b001000, 1'b1);
        do_edge(6'b000010, 1'b1);
        do_edge(6'b010000, 1'b1);
        check_eq("deal_pcard1", int'(bus.pcard1), 1);
        check_eq("deal_dcard2", int'(bus.dcard2), 4);
        check_eq("deal_pscore", int'(bus.pscore), 4);
        check_eq("deal_dscore", int'(bus.dscore), 6);
        check_eq("deal_count4", int'(bus.deal_count), 4);
        do_edge(6'b000100, 1'b1);
        check_eq("p3_pcard3", int'(bus.pcard3), 5);
        check_eq("p3_pscore", int'(bus.pscore), 9);
        do_edge(6'b100000, 1'b1);
        check_eq("d3_dcard3", int'(bus.dcard3), 6);
        check_eq("d3_dscore", int'(bus.dscore), 2);
        check_eq("d3_count6", int'(bus.deal_count), 6);

        // Face cards and wrap of the card source.
        do_edge(6'b000000, 1'b0);
        idle(9);
        check_eq("face_new10", int'(bus.new_card), 10);
        for (int k = 0; k < 4; k++) begin
            do_edge(6'b000001, 1'b1);
            check_eq("face_pcard1", int'(bus.pcard1), 10 + k);
            check_eq("face_pscore", int'(bus.pscore), 0);
        end
        check_eq("wrap_new1", int'(bus.new_card), 1);

        // Simultaneous loads, then mid-hand reset.
        do_edge(6'b000000, 1'b0);
        idle(6);
        check_eq("sim_new7", int'(bus.new_card), 7);
        do_edge(6'b111111, 1'b1);
        check_eq("sim_dcard1", int'(bus.dcard1), 7);
        check_eq("sim_pscore", int'(bus.pscore), 1);
        check_eq("sim_dscore", int'(bus.dscore), 1);
        check_eq("sim_count", int'(bus.deal_count), 6);
        do_edge(6'b000000, 1'b0);
        check_eq("midrst_pcard1", int'(bus.pcard1), 0);
        check_eq("midrst_new", int'(bus.new_card), 1);

        // Saturation of the deal counter.
        for (int k = 1; k <= 43; k++) begin
            do_edge(6'b111111, 1'b1);
            check_eq("sat_count", int'(bus.deal_count), (6 * k > 255) ? 255 : 6 * k);
        end
        idle(2);
        check_eq("sat_hold", int'(bus.deal_count), 255);

        // Random loads with occasional resets.
        do_edge(6'b000000, 1'b0);
        for (int k = 0; k < 400; k++) begin
            logic [5:0] ld;
            logic       rb;
            ld = 6'($urandom) & 6'($urandom);
            rb = ($urandom_range(0, 39) != 0);
            do_edge(ld, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end
endmodule
